msk_aes_share_loader: RTL

- Input stage directly upstream of the 32-bit masked AES core.
- Accepts the masked plaintext and masked key as a stream of 32-bit share words over a valid/ready port.
- Scatters each word into the core's bit-compact share layout: bit i of share j sits at index i*d+j.
- Presents the complete sharings to the core with a valid/ready handshake, then zeroizes its share registers.

---
 rtl/msk_aes_share_loader_pkg.sv | 27 ++
 rtl/msk_share_word_scatter.sv | 38 +++
 rtl/msk_aes_share_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/msk_aes_share_loader_pkg.sv
// Shared definitions for the masked AES share loader.
//   D            : default number of shares for the loader build
//   NWORDS       : 32-bit words per transfer (plaintext + key, all shares)
//   CNT_W        : width of the word counter
//   state_e      : loader FSM encoding (LOAD, PRESENT, CLEAR)
//   scatter_idx(): position of AES bit (32*w+b) of share s in the
//                  bit-compact layout, where bit i of share j sits at i*d+j
package msk_aes_share_loader_pkg;

    localparam int unsigned D      = 2;
    localparam int unsigned NWORDS = 8 * D;
    localparam int unsigned CNT_W  = $clog2(NWORDS);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CLEAR   = 2'd2
    } state_e;

    function automatic int unsigned scatter_idx(input int unsigned w,
                                                input int unsigned b,
                                                input int unsigned s,
                                                input int unsigned d);
        return (32 * w + b) * d + s;
    endfunction

endpackage

// File: rtl/msk_share_word_scatter.sv
// Places one 32-bit share word into a 128*d-bit bit-compact share register.
// Purely combinational: produces the register's next value.
//   w       : word index within the share (0..3)
//   s       : share index (0..d-1)
//   word_in : share word, bit b is AES bit 32*w+b of share s
//   we      : write strobe; when low reg_d equals reg_q
//   reg_q   : current register contents
//   reg_d   : next register contents (only the 32 addressed bits may change)
module msk_share_word_scatter
    import msk_aes_share_loader_pkg::*;
#(
    parameter int unsigned d  = D,
    parameter int unsigned SW = (d > 1) ? $clog2(d) : 1
) (
    input  logic [1:0]         w,
    input  logic [SW-1:0]      s,
    input  logic [31:0]        word_in,
    input  logic               we,
    input  logic [128*d-1:0]   reg_q,
    output logic [128*d-1:0]   reg_d
);

    // Each target bit is either held or copied straight from a single bit of
    // the incoming word; no two shares ever meet in the same expression.
    always_comb begin
        reg_d = reg_q;
        for (int unsigned ww = 0; ww < 4; ww++) begin
            for (int unsigned ss = 0; ss < d; ss++) begin
                if (we && (w == 2'(ww)) && (s == SW'(ss))) begin
                    for (int unsigned b = 0; b < 32; b++) begin
                        reg_d[scatter_idx(ww, b, ss, d)] = word_in[b];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/msk_aes_share_loader.sv
// Input stage in front of the 32-bit masked AES core. Collects 8*d share
// words (plaintext shares 0..d-1, then key shares 0..d-1, four words each),
// scatters them into bit-compact share registers, presents them to the core
// with valid_in until core_in_ready, then zeroizes the registers.
//   clk, rst        : clock; asynchronous active-low reset
//   word_in/valid   : incoming share word stream
//   word_ready      : word accepted this cycle when word_valid is high
//   sh_plaintext    : masked plaintext to the core (zero unless valid_in)
//   sh_key          : masked key to the core (zero unless valid_in)
//   valid_in        : complete sharings presented
//   core_in_ready   : core accepts the sharings
//   busy            : loader is not idle at the start of a transfer
module msk_aes_share_loader
    import msk_aes_share_loader_pkg::*;
#(
    parameter int unsigned d = D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        word_in,
    input  logic               word_valid,
    output logic               word_ready,
    output logic [128*d-1:0]   sh_plaintext,
    output logic [128*d-1:0]   sh_key,
    output logic               valid_in,
    input  logic               core_in_ready,
    output logic               busy
);

    // Package constants describe the default build; recompute for other d.
    localparam int unsigned NW = (d == D) ? NWORDS : 8 * d;
    localparam int unsigned CW = (d == D) ? CNT_W : $clog2(8 * d);
    localparam int unsigned SW = (d > 1) ? $clog2(d) : 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [128*d-1:0]   pt_q, pt_d, pt_scat;
    logic [128*d-1:0]   key_q, key_d, key_scat;

    // Word index decode: first half of the transfer is plaintext, second
    // half is key; within a half, four consecutive words per share.
    logic               sel;
    logic [CW-1:0]      half_idx;
    logic [SW-1:0]      sh_idx;
    logic [1:0]         w_idx;
    logic               accept;

    assign sel      = (cnt_q >= CW'(4 * d));
    assign half_idx = sel ? (cnt_q - CW'(4 * d)) : cnt_q;
    assign sh_idx   = SW'(half_idx >> 2);
    assign w_idx    = half_idx[1:0];
    assign accept   = word_valid && (state_q == ST_LOAD);

    msk_share_word_scatter #(.d(d), .SW(SW)) u_scatter_pt (
        .w       (w_idx),
        .s       (sh_idx),
        .word_in (word_in),
        .we      (accept && !sel),
        .reg_q   (pt_q),
        .reg_d   (pt_scat)
    );

    msk_share_word_scatter #(.d(d), .SW(SW)) u_scatter_key (
        .w       (w_idx),
        .s       (sh_idx),
        .word_in (word_in),
        .we      (accept && sel),
        .reg_q   (key_q),
        .reg_d   (key_scat)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pt_d       = pt_scat;
        key_d      = key_scat;
        word_ready = 1'b0;
        valid_in   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    if (cnt_q == CW'(NW - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PRESENT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                valid_in = 1'b1;
                if (core_in_ready) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pt_d    = '0;
                key_d   = '0;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            pt_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
        end
    end

    // Partial sharings never leave the block.
    assign sh_plaintext = valid_in ? pt_q  : '0;
    assign sh_key       = valid_in ? key_q : '0;
    assign busy         = !((state_q == ST_LOAD) && (cnt_q == '0));

endmodule
